// File: rtl/mem_stage_sram_if.sv
// SRAM bus between the memory stage and the external 16-bit SRAM.
interface mem_stage_sram_if;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   modport master (
      output sram_addr,
      output sram_dq_out,
      output sram_dq_oe,
      output sram_we_n,
      input  sram_dq_in
   );

   modport slave (
      input  sram_addr,
      input  sram_dq_out,
      input  sram_dq_oe,
      input  sram_we_n,
      output sram_dq_in
   );
endinterface

// File: rtl/mem_stage_sram.sv
// Memory stage + MEM/WB register. LDR/STR go to a 16-bit SRAM as two
// half-word phases (LO then HI); everything else passes straight through.
module mem_stage_sram #(
   parameter int unsigned SRAM_WAIT = 5,
   parameter logic [31:0] MEM_BASE  = 32'd1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              dst,
   input  logic [31:0]             ALU_res,
   input  logic [31:0]             Val_Rm,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic                    WB_en,
   output logic                    freeze,
   mem_stage_sram_if.master        sram,
   output logic [3:0]              WB_dst,
   output logic [31:0]             WB_ALU_res,
   output logic [31:0]             WB_mem_data,
   output logic                    WB_mem_read,
   output logic                    WB_en_out
);

   localparam int unsigned CW   = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   lo_q;
   logic [15:0]   hi_q;

   logic        mem_op;
   logic        is_read;
   logic        is_write;
   logic        in_phase;
   logic        borrow;
   logic [16:0] word_idx;

   assign mem_op   = mem_read | mem_write;
   assign is_read  = mem_read;                 // read+write together counts as read
   assign is_write = mem_write & ~mem_read;
   assign in_phase = (state_q == LO) || (state_q == HI);

   // Word index = (ALU_res - MEM_BASE)[18:2]; the low-bit borrow is folded in
   // so only the address bits that reach the SRAM are subtracted.
   assign borrow   = ALU_res[1:0] < MEM_BASE[1:0];
   assign word_idx = ALU_res[18:2] - MEM_BASE[18:2] - 17'(borrow);

   assign freeze           = mem_op && (state_q != DONE);
   assign sram.sram_addr   = {word_idx, state_q == HI};
   assign sram.sram_dq_out = (state_q == HI) ? Val_Rm[31:16] : Val_Rm[15:0];
   assign sram.sram_dq_oe  = is_write && in_phase;
   assign sram.sram_we_n   = !(is_write && in_phase && (cnt_q < LAST));

   // Access sequencer: phase timing and read half-word capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (mem_op) state_q <= LO;
            end
            LO: begin
               if (cnt_q == LAST) begin
                  state_q <= HI;
                  cnt_q   <= '0;
                  if (is_read) lo_q <= sram.sram_dq_in;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            HI: begin
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  if (is_read) hi_q <= sram.sram_dq_in;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while frozen, otherwise capture the stage result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         WB_dst      <= '0;
         WB_ALU_res  <= '0;
         WB_mem_data <= '0;
         WB_mem_read <= 1'b0;
         WB_en_out   <= 1'b0;
      end else if (freeze) begin
         WB_mem_read <= 1'b0;
         WB_en_out   <= 1'b0;
      end else begin
         WB_dst      <= dst;
         WB_ALU_res  <= ALU_res;
         WB_mem_data <= {hi_q, lo_q};
         WB_mem_read <= mem_read;
         WB_en_out   <= WB_en;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: fixed vectors, reset abort, then random ops
// checked against a word-level memory model.
module tb_mem_stage_sram;
   localparam int unsigned W = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  dst;
   logic [31:0] ALU_res, Val_Rm;
   logic        mem_read, mem_write, WB_en;
   logic        freeze;
   logic [3:0]  WB_dst;
   logic [31:0] WB_ALU_res, WB_mem_data;
   logic        WB_mem_read, WB_en_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_stage_sram_if sif ();

   mem_stage_sram #(.SRAM_WAIT(W), .MEM_BASE(32'd1024)) dut (
      .clk         (clk),
      .rst         (rst),
      .dst         (dst),
      .ALU_res     (ALU_res),
      .Val_Rm      (Val_Rm),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .WB_en       (WB_en),
      .freeze      (freeze),
      .sram        (sif),
      .WB_dst      (WB_dst),
      .WB_ALU_res  (WB_ALU_res),
      .WB_mem_data (WB_mem_data),
      .WB_mem_read (WB_mem_read),
      .WB_en_out   (WB_en_out)
   );

   // External SRAM: asynchronous read, write on clock while we_n is low.
   logic [15:0] sram_mem [0:262143];
   assign sif.sram_dq_in = sram_mem[sif.sram_addr];
   always @(posedge clk) begin
      if (!sif.sram_we_n) sram_mem[sif.sram_addr] <= sif.sram_dq_out;
   end

   // Reference: one 32-bit word per SRAM word index.
   logic [31:0] ref_mem [int unsigned];

   logic [17:0] obs_addr_lo, obs_addr_hi;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Presents one instruction (called just after a falling edge) and follows
   // it until it lands in the MEM/WB register.
   task automatic run_op(input logic [3:0] d, input logic [31:0] a, input logic [31:0] v,
                         input logic rd, input logic wr, input logic en);
      int unsigned key;
      logic [17:0] exp_lo, exp_hi;
      int fz, we_lo, we_hi, we_bad, oe_cnt, bub, cyc;
      logic is_mem, is_wr;
      dst = d; ALU_res = a; Val_Rm = v; mem_read = rd; mem_write = wr; WB_en = en;
      #1;
      key    = ((a - 32'd1024) >> 2) & 32'h1FFFF;
      exp_lo = {key[16:0], 1'b0};
      exp_hi = {key[16:0], 1'b1};
      is_mem = rd | wr;
      is_wr  = wr & ~rd;
      fz = 0; we_lo = 0; we_hi = 0; we_bad = 0; oe_cnt = 0; bub = 0; cyc = 0;
      obs_addr_lo = 'x; obs_addr_hi = 'x;
      while (freeze === 1'b1 && cyc < 200) begin
         fz++;
         if (fz == 2)           obs_addr_lo = sif.sram_addr;
         if (fz == int'(W) + 2) obs_addr_hi = sif.sram_addr;
         if (sif.sram_we_n === 1'b0) begin
            if (sif.sram_addr == exp_lo && sif.sram_dq_out == v[15:0])       we_lo++;
            else if (sif.sram_addr == exp_hi && sif.sram_dq_out == v[31:16]) we_hi++;
            else                                                             we_bad++;
         end
         if (sif.sram_dq_oe === 1'b1) oe_cnt++;
         if (fz > 1 && WB_en_out !== 1'b0) bub++;
         @(negedge clk); #1;
         cyc++;
      end
      chk("freeze_cycles", fz, is_mem ? 1 + 2 * W : 0);
      if (is_mem) begin
         chk("we_low_lo", we_lo, is_wr ? W - 1 : 0);
         chk("we_low_hi", we_hi, is_wr ? W - 1 : 0);
         chk("we_bad", we_bad, 0);
         chk("oe_cycles", oe_cnt, is_wr ? 2 * W : 0);
         chk("wb_bubble", bub, 0);
      end
      @(posedge clk); @(negedge clk); #1;
      chk("WB_dst", WB_dst, d);
      chk("WB_ALU_res", WB_ALU_res, a);
      chk("WB_en_out", WB_en_out, en);
      chk("WB_mem_read", WB_mem_read, rd);
      if (rd && ref_mem.exists(key)) chk("WB_mem_data", WB_mem_data, ref_mem[key]);
      if (is_wr) ref_mem[key] = v;
   endtask

   typedef struct {
      logic [3:0]  d;
      logic [31:0] a;
      logic [31:0] v;
      logic        rd, wr, en;
      logic [31:0] exp_data;
      logic [17:0] exp_addr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{4'd3, 32'h55,  32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        18'h0};
      vecs[1] = '{4'd5, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        18'h00002};
      vecs[2] = '{4'd7, 32'd1028, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 18'h00002};
      vecs[3] = '{4'd2, 32'd1020, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,        18'h3FFFE};
      vecs[4] = '{4'd9, 32'd1020, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678, 18'h3FFFE};
      vecs[5] = '{4'd4, 32'hAA,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        18'h0};
      vecs[6] = '{4'd1, 32'd1028, 32'h0BADF00D, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 18'h00002};
      vecs[7] = '{4'd6, 32'd1031, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 18'h00002};

      rst = 1'b0; dst = '0; ALU_res = '0; Val_Rm = '0;
      mem_read = 1'b0; mem_write = 1'b0; WB_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_WB_en_out", WB_en_out, 0);
      chk("rst_WB_dst", WB_dst, 0);
      chk("rst_WB_ALU_res", WB_ALU_res, 0);
      chk("rst_WB_mem_data", WB_mem_data, 0);
      chk("rst_we_n", sif.sram_we_n, 1);
      chk("rst_dq_oe", sif.sram_dq_oe, 0);
      chk("rst_freeze", freeze, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].d, vecs[i].a, vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].en);
         if (vecs[i].rd) chk("vec_data", WB_mem_data, vecs[i].exp_data);
         if (vecs[i].rd | vecs[i].wr) begin
            chk("vec_addr_lo", obs_addr_lo, vecs[i].exp_addr);
            chk("vec_addr_hi", obs_addr_hi, vecs[i].exp_addr | 18'h1);
         end
      end

      // Reset in the middle of the HI phase of a store.
      dst = 4'd8; ALU_res = 32'd1028; Val_Rm = 32'hCAFEF00D;
      mem_read = 1'b0; mem_write = 1'b1; WB_en = 1'b0;
      repeat (W + 3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_we_n", sif.sram_we_n, 1);
      chk("abort_dq_oe", sif.sram_dq_oe, 0);
      chk("abort_WB_dst", WB_dst, 0);
      chk("abort_WB_ALU_res", WB_ALU_res, 0);
      chk("abort_WB_mem_data", WB_mem_data, 0);
      chk("abort_WB_mem_read", WB_mem_read, 0);
      chk("abort_WB_en_out", WB_en_out, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_refreeze", freeze, 1);
      run_op(4'd8, 32'd1028, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
      run_op(4'd10, 32'd1028, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("abort_reload", WB_mem_data, 32'hCAFEF00D);

      // Random mix against the word-level model.
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         int unsigned kind;
         kind = $urandom_range(0, 9);
         a = 32'd1024 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) a = a + 32'h0010_0000;
         if (kind < 2)
            run_op(4'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'($urandom));
         else if (kind < 6)
            run_op(4'($urandom), a, $urandom, 1'b0, 1'b1, 1'b0);
         else if (kind < 9)
            run_op(4'($urandom), a, $urandom, 1'b1, 1'b0, 1'b1);
         else
            run_op(4'($urandom), a, $urandom, 1'b1, 1'b1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
